// File: rtl/ram_dp_sync_be.sv
// ram_dp_sync_be: synchronous true-dual-port RAM with per-byte write enables,
// registered reads (latency 1), read-first cross-port behaviour, port-0-wins
// write collision handling and a power-up clear sequencer.
// Optional feature macro: RAM_PARITY_EN (per-byte even parity with error flags
// and a port 0 parity-inversion hook).
module ram_dp_sync_be #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned RAM_DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic                    cs_0,
  input  logic                    we_0,
  input  logic [DATA_WIDTH/8-1:0] be_0,
  input  logic [ADDR_WIDTH-1:0]   address_0,
  input  logic [DATA_WIDTH-1:0]   wdata_0,
  output logic [DATA_WIDTH-1:0]   rdata_0,
  output logic                    rvalid_0,
  input  logic                    cs_1,
  input  logic                    we_1,
  input  logic [DATA_WIDTH/8-1:0] be_1,
  input  logic [ADDR_WIDTH-1:0]   address_1,
  input  logic [DATA_WIDTH-1:0]   wdata_1,
  output logic [DATA_WIDTH-1:0]   rdata_1,
  output logic                    rvalid_1,
  output logic                    collision,
  output logic                    perr_0,
  output logic                    perr_1,
  input  logic                    perr_inj
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned IW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state;
  logic [IW-1:0]         clr_cnt;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic          in0, in1;
  logic          wr0, wr1, rd0, rd1, coll;
  logic [IW-1:0] idx0, idx1;
  logic          pmis0, pmis1;

  // Request decode: accesses only count once the clear sequence has finished
  always_comb begin
    in0  = 32'(address_0) < RAM_DEPTH;
    in1  = 32'(address_1) < RAM_DEPTH;
    idx0 = in0 ? address_0[IW-1:0] : '0;
    idx1 = in1 ? address_1[IW-1:0] : '0;
    wr0  = (state == ST_READY) && cs_0 && we_0;
    wr1  = (state == ST_READY) && cs_1 && we_1;
    rd0  = (state == ST_READY) && cs_0 && !we_0;
    rd1  = (state == ST_READY) && cs_1 && !we_1;
    coll = wr0 && wr1 && (address_0 == address_1);
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par [RAM_DEPTH];
  logic [NB-1:0] wpar0, wpar1, chk0, chk1;

  // Parity generation for writes and recomputation over the words being read
  always_comb begin
    wpar0 = '0;
    wpar1 = '0;
    chk0  = '0;
    chk1  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wpar0[i] = (^wdata_0[8*i +: 8]) ^ perr_inj;
      wpar1[i] = ^wdata_1[8*i +: 8];
      chk0[i]  = ^mem[idx0][8*i +: 8];
      chk1[i]  = ^mem[idx1][8*i +: 8];
    end
    pmis0 = |(chk0 ^ par[idx0]);
    pmis1 = |(chk1 ^ par[idx1]);
  end
`else
  logic unused_perr_inj;
  assign unused_perr_inj = perr_inj;
  assign pmis0 = 1'b0;
  assign pmis1 = 1'b0;
`endif

  // Clear sequencer, registered read ports and byte-lane writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      ready     <= 1'b0;
      rdata_0   <= '0;
      rdata_1   <= '0;
      rvalid_0  <= 1'b0;
      rvalid_1  <= 1'b0;
      collision <= 1'b0;
      perr_0    <= 1'b0;
      perr_1    <= 1'b0;
    end else begin
      rvalid_0  <= 1'b0;
      rvalid_1  <= 1'b0;
      collision <= 1'b0;
      perr_0    <= 1'b0;
      perr_1    <= 1'b0;
      case (state)
        ST_CLEAR: begin
          mem[clr_cnt] <= '0;
`ifdef RAM_PARITY_EN
          par[clr_cnt] <= '0;
`endif
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == IW'(RAM_DEPTH - 1)) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        ST_READY: begin
          // Reads sample the array before this edge's writes land (read-first)
          if (rd0) begin
            rvalid_0 <= 1'b1;
            rdata_0  <= in0 ? mem[idx0] : '0;
            perr_0   <= in0 && pmis0;
          end
          if (rd1) begin
            rvalid_1 <= 1'b1;
            rdata_1  <= in1 ? mem[idx1] : '0;
            perr_1   <= in1 && pmis1;
          end
          collision <= coll;
          // Port 1 write is dropped entirely when port 0 writes the same word
          for (int unsigned i = 0; i < NB; i++) begin
            if (wr1 && in1 && !coll && be_1[i]) begin
              mem[idx1][8*i +: 8] <= wdata_1[8*i +: 8];
`ifdef RAM_PARITY_EN
              par[idx1][i] <= wpar1[i];
`endif
            end
            if (wr0 && in0 && be_0[i]) begin
              mem[idx0][8*i +: 8] <= wdata_0[8*i +: 8];
`ifdef RAM_PARITY_EN
              par[idx0][i] <= wpar0[i];
`endif
            end
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule
